// File: rtl/can_rx_deframer.sv
// CAN 2.0A receive deframer: bus integration, destuffing,
// CRC-15 check, acceptance filtering and frame field capture.
module can_rx_deframer #(
  parameter logic [10:0] FILTER_ID   = 11'h000,
  parameter logic [10:0] FILTER_MASK = 11'h000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bit_en,
  input  logic        can_hi,
  input  logic        can_lo,
  output logic        frame_valid,
  output logic [10:0] frame_id,
  output logic        frame_rtr,
  output logic [3:0]  frame_dlc,
  output logic [63:0] frame_data,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err,
  output logic        busy
);

  typedef enum logic [3:0] {
    S_INTEGRATE, S_IDLE, S_ARB, S_CTRL,
    S_DATA, S_CRC, S_CRC_DEL, S_ACK_SLOT,
    S_ACK_DEL, S_EOF, S_ERROR
  } state_t;

  state_t state, state_n;

  logic [6:0]  cnt;
  logic [2:0]  run_cnt;
  logic        last_bit;
  logic [11:0] arb_sr;
  logic [3:0]  dlc;
  logic [63:0] data_sr;
  logic [14:0] crc_rx;
  logic [14:0] crc_calc;

  logic        bit_s;
  logic        fault;
  logic        destuff;
  logic        is_stuff;
  logic [3:0]  dlc_full;
  logic [6:0]  data_last;
  logic [5:0]  data_idx;
  logic        id_match;
  logic        form_n;
  logic        stuff_n;
  logic        crc_n;
  logic        accept_n;

  function automatic logic [14:0] crc_next(
    input logic [14:0] c,
    input logic        b
  );
    crc_next = {c[13:0], 1'b0} ^
               ((b ^ c[14]) ? 15'h4599 : 15'h0000);
  endfunction

  assign bit_s    = ~can_hi;
  assign fault    = (state != S_IDLE) &&
                    (state != S_INTEGRATE) &&
                    (can_hi == can_lo);
  // A stuff bit may still follow the last CRC bit.
  assign destuff  = state inside {S_ARB, S_CTRL, S_DATA,
                                  S_CRC, S_CRC_DEL};
  assign is_stuff = destuff && (run_cnt == 3'd5);
  assign dlc_full = {dlc[2:0], bit_s};
  assign data_last = dlc[3] ? 7'd63 :
                     {1'b0, dlc[2:0], 3'b000} - 7'd1;
  assign data_idx = 6'd63 - cnt[5:0];
  assign id_match = ((arb_sr[11:1] ^ FILTER_ID) &
                     FILTER_MASK) == 11'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_INTEGRATE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    form_n   = 1'b0;
    stuff_n  = 1'b0;
    crc_n    = 1'b0;
    accept_n = 1'b0;
    if (bit_en) begin
      if (fault) begin
        form_n  = 1'b1;
        state_n = S_ERROR;
      end else if (is_stuff) begin
        if (bit_s == last_bit) begin
          stuff_n = 1'b1;
          state_n = S_ERROR;
        end
      end else begin
        unique case (state)
          S_INTEGRATE, S_ERROR:
            if (bit_s && cnt == 7'd10) state_n = S_IDLE;
          S_IDLE:
            if (!bit_s) state_n = S_ARB;
          S_ARB:
            if (cnt == 7'd11) state_n = S_CTRL;
          S_CTRL: begin
            if (cnt == 7'd0 && bit_s) begin
              form_n  = 1'b1;
              state_n = S_ERROR;
            end else if (cnt == 7'd5) begin
              state_n = (arb_sr[0] || dlc_full == 4'd0) ?
                        S_CRC : S_DATA;
            end
          end
          S_DATA:
            if (cnt == data_last) state_n = S_CRC;
          S_CRC:
            if (cnt == 7'd14) state_n = S_CRC_DEL;
          S_CRC_DEL: begin
            if (crc_calc != crc_rx) begin
              crc_n   = 1'b1;
              state_n = S_ERROR;
            end else if (!bit_s) begin
              form_n  = 1'b1;
              state_n = S_ERROR;
            end else begin
              state_n = S_ACK_SLOT;
            end
          end
          S_ACK_SLOT:
            state_n = S_ACK_DEL;
          S_ACK_DEL: begin
            if (!bit_s) begin
              form_n  = 1'b1;
              state_n = S_ERROR;
            end else begin
              state_n = S_EOF;
            end
          end
          S_EOF: begin
            if (!bit_s) begin
              form_n  = 1'b1;
              state_n = S_ERROR;
            end else if (cnt == 7'd6) begin
              state_n  = S_IDLE;
              accept_n = id_match;
            end
          end
          default:
            state_n = S_ERROR;
        endcase
      end
    end
  end

  always_comb begin
    busy = (state != S_IDLE) && (state != S_INTEGRATE);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt         <= '0;
      run_cnt     <= '0;
      last_bit    <= 1'b0;
      arb_sr      <= '0;
      dlc         <= '0;
      data_sr     <= '0;
      crc_rx      <= '0;
      crc_calc    <= '0;
      frame_valid <= 1'b0;
      frame_id    <= '0;
      frame_rtr   <= 1'b0;
      frame_dlc   <= '0;
      frame_data  <= '0;
      crc_err     <= 1'b0;
      stuff_err   <= 1'b0;
      form_err    <= 1'b0;
    end else begin
      frame_valid <= accept_n;
      crc_err     <= crc_n;
      stuff_err   <= stuff_n;
      form_err    <= form_n;
      if (accept_n) begin
        frame_id   <= arb_sr[11:1];
        frame_rtr  <= arb_sr[0];
        frame_dlc  <= dlc;
        frame_data <= data_sr;
      end
      if (bit_en) begin
        if (state_n != state)
          cnt <= '0;
        else if (state == S_INTEGRATE || state == S_ERROR)
          cnt <= bit_s ? cnt + 7'd1 : 7'd0;
        else if (state != S_IDLE && !is_stuff)
          cnt <= cnt + 7'd1;

        if (state == S_IDLE && !bit_s) begin
          last_bit <= 1'b0;
          run_cnt  <= 3'd1;
          crc_calc <= '0;
          arb_sr   <= '0;
          dlc      <= '0;
          data_sr  <= '0;
          crc_rx   <= '0;
        end else if (destuff) begin
          if (is_stuff) begin
            last_bit <= bit_s;
            run_cnt  <= 3'd1;
          end else begin
            if (bit_s == last_bit) begin
              run_cnt <= run_cnt + 3'd1;
            end else begin
              run_cnt  <= 3'd1;
              last_bit <= bit_s;
            end
            if (state inside {S_ARB, S_CTRL, S_DATA})
              crc_calc <= crc_next(crc_calc, bit_s);
            if (state == S_ARB)
              arb_sr <= {arb_sr[10:0], bit_s};
            if (state == S_CTRL && cnt >= 7'd2)
              dlc <= {dlc[2:0], bit_s};
            if (state == S_DATA)
              data_sr[data_idx] <= bit_s;
            if (state == S_CRC)
              crc_rx <= {crc_rx[13:0], bit_s};
          end
        end
      end
    end
  end

endmodule
